snake_dir_ctrl: RTL and testbench
=================================

// Module: snake_dir_ctrl
// PURPOSE
//  Upstream of the head-position stage. Synchronises and debounces the four active-low
//  direction buttons, holds the committed move direction, and issues the periodic move tick.
//  Rejects 180-degree reversals and allows at most one turn per move period.
//  Outputs o_Way/o_Push feed the head stage; o_Move_Tick strobes the head and body update.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000   cycles an input must stay changed before it is accepted (10 ms @ 25 MHz)
//  MOVE_PERIOD      5000000  cycles between move ticks in RUN (5 moves/s @ 25 MHz)
// PORTS
//  i_Clk        in   1  system clock
//  i_Rst        in   1  reset, asynchronous, active-high
//  i_Push       in   4  raw buttons, active-low; bit 0=UP, 1=DOWN, 2=RIGHT, 3=LEFT
//  i_Game_Over  in   1  level from collision logic; high = snake dead
//  o_Push       out  4  debounced buttons, active-low, same bit map
//  o_Way        out  2  committed direction: 0=UP, 1=DOWN, 2=RIGHT, 3=LEFT
//  o_Move_Tick  out  1  one-cycle strobe; the head advances one cell in direction o_Way
//  o_State      out  2  0=IDLE, 1=RUN, 2=HALT
// BEHAVIOUR
//  Reset (async): sync flops and o_Push = 4'b1111; debounce and tick counters = 0;
//   o_Way = RIGHT; pending = RIGHT; o_Move_Tick = 0; o_State = IDLE.
//  Sync: 2-flop synchroniser per bit. Each synchroniser flop resets to 1.
//  Debounce, per bit:
//   - sync == stable: counter cleared.
//   - otherwise: counter increments; at DEBOUNCE_CYCLES-1, stable takes the sync value and the counter clears.
//   - Counter width is $clog2(DEBOUNCE_CYCLES).
//   - A change is visible on o_Push DEBOUNCE_CYCLES+2 cycles after the raw edge.
//  Press event: debounced bit goes 1->0; asserted for one cycle only.
//   - Several press events in one cycle: priority UP > DOWN > RIGHT > LEFT.
//  Direction request: accepted only if it is not the opposite of o_Way
//   (UP<->DOWN, RIGHT<->LEFT).
//   - An accepted request overwrites pending; the last accepted request in a period wins.
//   - A request equal to o_Way is accepted and is harmless.
//  FSM:
//   IDLE: tick counter held at 0; o_Move_Tick = 0.
//    - Any press event -> RUN on the next edge; pending is updated by the request rule.
//   RUN: tick counter runs 0..MOVE_PERIOD-1 and wraps.
//    - On the edge where the counter wraps, o_Way <= pending and o_Move_Tick <= 1 (high for one cycle).
//    - So during the strobe cycle o_Way already holds the new direction.
//    - The first tick comes MOVE_PERIOD cycles after entering RUN.
//    - i_Game_Over = 1 -> HALT.
//   HALT: counter frozen; no ticks; presses ignored.
//    - i_Game_Over = 0 -> IDLE, with o_Way = pending = RIGHT and the counter cleared.
//  Reversal is checked against the committed o_Way, never against pending.
//   - Example: UP then LEFT within one period, with o_Way = RIGHT: UP is accepted, LEFT is rejected.
//  Simultaneous events:
//   - Game over and wrap in the same cycle: game over wins; no tick; o_Way unchanged.
//   - Press event in the wrap cycle: the commit uses pending as it was before the press;
//     the new request lands in pending for the next period.
//  Reset mid-period or mid-debounce: everything returns to reset values immediately; no strobe.
// TESTING (DEBOUNCE_CYCLES=4, MOVE_PERIOD=8)
//  1. Reset, no input -> o_Push=1111, o_Way=2, o_State=0, o_Move_Tick never high over 100 cycles.
//  2. i_Push[0] low 3 cycles then high (bounce) -> o_Push stays 1111; held low 10 cycles ->
//     o_Push[0]=0 at cycle 6, o_State=1, first o_Move_Tick 8 cycles later with o_Way=0.
//  3. RUN with o_Way=0, press DOWN -> rejected; next tick keeps o_Way=0. Press LEFT -> next tick o_Way=3.
//  4. o_Way=2, press UP then LEFT in the same period -> tick commits o_Way=0 (LEFT rejected);
//     press LEFT in the following period -> o_Way=3.
//  5. Raise i_Game_Over in the wrap cycle -> no tick, o_State=2; drop it -> o_State=0, o_Way=2.
//  6. Assert i_Rst for 1 cycle mid-period in RUN -> o_State=0, o_Way=2, counters 0, no spurious tick.

Source files
------------

// File: rtl/snake_dir_ctrl_if.sv
// Button/direction bundle between the direction controller and the game logic.
// slave = controller side, master = driver of the raw inputs.
interface snake_dir_ctrl_if;
  logic [3:0] i_Push;
  logic       i_Game_Over;
  logic [3:0] o_Push;
  logic [1:0] o_Way;
  logic       o_Move_Tick;
  logic [1:0] o_State;

  modport slave (
    input  i_Push,
    input  i_Game_Over,
    output o_Push,
    output o_Way,
    output o_Move_Tick,
    output o_State
  );

  modport master (
    output i_Push,
    output i_Game_Over,
    input  o_Push,
    input  o_Way,
    input  o_Move_Tick,
    input  o_State
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: button sync/debounce, reversal-filtered turn requests,
// committed direction and periodic move strobe.
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MOVE_PERIOD     = 5000000
) (
  input logic             i_Clk,
  input logic             i_Rst,
  snake_dir_ctrl_if.slave bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned MV_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MV_W-1:0] MV_LAST   = MV_W'(MOVE_PERIOD - 1);
  localparam logic [1:0]      WAY_RIGHT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [3:0]      r_stable;
  logic [DB_W-1:0] r_db_cnt [4];
  logic [3:0]      w_db_done;
  logic [3:0]      w_press;

  logic            w_req_vld;
  logic [1:0]      w_req;
  logic            w_req_ok;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MV_W-1:0] r_mv_cnt;
  logic [MV_W-1:0] w_mv_cnt_nxt;
  logic [1:0]      r_way;
  logic [1:0]      w_way_nxt;
  logic [1:0]      r_pend;
  logic [1:0]      w_pend_nxt;
  logic            r_tick;
  logic            w_tick_nxt;

  // Two-flop synchroniser, idles at the released (high) level
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= bus.i_Push;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_db_done = '0;
    for (int i = 0; i < 4; i++) begin
      w_db_done[i] = (r_sync2[i] != r_stable[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_stable <= 4'b1111;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_done[i]) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press event fires in the cycle the debounced bit commits its 1->0 edge
  assign w_press = w_db_done & r_stable & ~r_sync2;

  always_comb begin
    w_req_vld = |w_press;
    w_req     = 2'd0;
    if (w_press[0])      w_req = 2'd0;
    else if (w_press[1]) w_req = 2'd1;
    else if (w_press[2]) w_req = 2'd2;
    else if (w_press[3]) w_req = 2'd3;
  end

  // Opposite directions differ only in bit 0; compare against the committed way
  assign w_req_ok = w_req_vld && (w_req != (r_way ^ 2'b01));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_vld)        w_state_nxt = S_RUN;
      S_RUN:   if (bus.i_Game_Over)  w_state_nxt = S_HALT;
      S_HALT:  if (!bus.i_Game_Over) w_state_nxt = S_IDLE;
      default:                       w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_mv_cnt_nxt = r_mv_cnt;
    w_way_nxt    = r_way;
    w_pend_nxt   = r_pend;
    w_tick_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_mv_cnt_nxt = '0;
        if (w_req_ok) w_pend_nxt = w_req;
      end
      S_RUN: begin
        // Game over freezes the period and suppresses a coincident commit
        if (!bus.i_Game_Over) begin
          if (w_req_ok) w_pend_nxt = w_req;
          if (r_mv_cnt == MV_LAST) begin
            w_mv_cnt_nxt = '0;
            w_way_nxt    = r_pend;
            w_tick_nxt   = 1'b1;
          end else begin
            w_mv_cnt_nxt = r_mv_cnt + MV_W'(1);
          end
        end
      end
      S_HALT: begin
        if (!bus.i_Game_Over) begin
          w_mv_cnt_nxt = '0;
          w_way_nxt    = WAY_RIGHT;
          w_pend_nxt   = WAY_RIGHT;
        end
      end
      default: begin
        w_mv_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_mv_cnt <= '0;
      r_way    <= WAY_RIGHT;
      r_pend   <= WAY_RIGHT;
      r_tick   <= 1'b0;
    end else begin
      r_mv_cnt <= w_mv_cnt_nxt;
      r_way    <= w_way_nxt;
      r_pend   <= w_pend_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign bus.o_Push      = r_stable;
  assign bus.o_Way       = r_way;
  assign bus.o_Move_Tick = r_tick;
  assign bus.o_State     = 2'(r_state);

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Directed bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4, MOVE_PERIOD=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_snake_dir_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_ticks  = 0;

  always #5 clk = ~clk;

  snake_dir_ctrl_if bus ();

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .MOVE_PERIOD     (8)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always @(negedge clk) if (bus.o_Move_Tick === 1'b1) n_ticks++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold one button low long enough to be accepted, then release it
  task automatic press_btn(input int b);
    bus.i_Push[b] = 1'b0;
    cyc(6);
    bus.i_Push[b] = 1'b1;
  endtask

  task automatic wait_tick(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (bus.o_Move_Tick !== 1'b1 && cycles < budget);
    check({tag, "_seen"}, 32'(bus.o_Move_Tick), 1);
  endtask

  // From a tick: press one button inside the next period, expect the following tick's way
  task automatic step(input int b, input logic [1:0] exp_way, input string tag);
    int c;
    cyc(1);
    check({tag, "_strobe_low"}, 32'(bus.o_Move_Tick), 0);
    press_btn(b);
    wait_tick(tag, 16, c);
    check({tag, "_lat"}, c, 1);
    check({tag, "_way"}, 32'(bus.o_Way), 32'(exp_way));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int c;
    int t0;

    // 1: reset values and quiet idle
    rst             = 1'b1;
    bus.i_Push      = 4'b1111;
    bus.i_Game_Over = 1'b0;
    cyc(2);
    check("rst_push",  32'(bus.o_Push), 32'hF);
    check("rst_way",   32'(bus.o_Way), 2);
    check("rst_state", 32'(bus.o_State), 0);
    check("rst_tick",  32'(bus.o_Move_Tick), 0);
    rst = 1'b0;
    t0 = n_ticks;
    cyc(100);
    check("idle_no_tick", 32'(n_ticks - t0), 0);
    check("idle_state",   32'(bus.o_State), 0);

    // 2: bounce rejected, then a clean UP press starts the game
    bus.i_Push[0] = 1'b0;
    cyc(3);
    bus.i_Push[0] = 1'b1;
    cyc(10);
    check("bounce_push",  32'(bus.o_Push), 32'hF);
    check("bounce_state", 32'(bus.o_State), 0);
    bus.i_Push[0] = 1'b0;
    cyc(5);
    check("db_c5_push", 32'(bus.o_Push), 32'hF);
    cyc(1);
    check("db_c6_push",  32'(bus.o_Push), 32'hE);
    check("db_c6_state", 32'(bus.o_State), 1);
    cyc(4);
    bus.i_Push[0] = 1'b1;
    wait_tick("first", 16, c);
    check("first_lat", c, 4);
    check("first_way", 32'(bus.o_Way), 0);

    // 3: reversal rejected, legal turn accepted; steer back to RIGHT
    step(1, 2'd0, "rev_down");
    step(3, 2'd3, "turn_left");
    step(0, 2'd0, "turn_up");
    step(2, 2'd2, "turn_right");

    // 4: UP then LEFT in one period with way=RIGHT: LEFT is checked against RIGHT
    cyc(6);
    bus.i_Push[0] = 1'b0;
    cyc(2);
    check("seq_tick_now", 32'(bus.o_Move_Tick), 1);
    check("seq_way_old",  32'(bus.o_Way), 2);
    bus.i_Push[3] = 1'b0;
    cyc(6);
    bus.i_Push[0] = 1'b1;
    bus.i_Push[3] = 1'b1;
    wait_tick("seq", 16, c);
    check("seq_lat", c, 2);
    check("seq_way", 32'(bus.o_Way), 0);
    wait_tick("seq_hold", 16, c);
    check("seq_hold_lat", c, 8);
    check("seq_hold_way", 32'(bus.o_Way), 0);
    step(3, 2'd3, "next_left");

    // 5: game over on the wrap edge, presses ignored in HALT, release to IDLE
    cyc(7);
    bus.i_Game_Over = 1'b1;
    cyc(1);
    check("go_no_tick", 32'(bus.o_Move_Tick), 0);
    check("go_state",   32'(bus.o_State), 2);
    check("go_way",     32'(bus.o_Way), 3);
    t0 = n_ticks;
    press_btn(0);
    cyc(4);
    check("halt_state",   32'(bus.o_State), 2);
    check("halt_no_tick", 32'(n_ticks - t0), 0);
    bus.i_Game_Over = 1'b0;
    cyc(1);
    check("rel_state", 32'(bus.o_State), 0);
    check("rel_way",   32'(bus.o_Way), 2);
    t0 = n_ticks;
    cyc(20);
    check("rel_idle_no_tick", 32'(n_ticks - t0), 0);
    check("rel_idle_state",   32'(bus.o_State), 0);

    // 7: simultaneous UP+DOWN from IDLE, UP has priority
    bus.i_Push = 4'b1100;
    cyc(6);
    check("prio_state", 32'(bus.o_State), 1);
    bus.i_Push = 4'b1111;
    wait_tick("prio", 16, c);
    check("prio_lat", c, 8);
    check("prio_way", 32'(bus.o_Way), 0);

    // 6: reset mid-period and mid-debounce
    cyc(1);
    bus.i_Push[1] = 1'b0;
    cyc(2);
    rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(bus.o_State), 0);
    check("mid_rst_way",   32'(bus.o_Way), 2);
    check("mid_rst_tick",  32'(bus.o_Move_Tick), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.i_Push[1] = 1'b1;
    t0 = n_ticks;
    cyc(30);
    check("post_rst_no_tick", 32'(n_ticks - t0), 0);
    check("post_rst_state",   32'(bus.o_State), 0);
    check("post_rst_push",    32'(bus.o_Push), 32'hF);
    bus.i_Push[0] = 1'b0;
    cyc(6);
    check("restart_state", 32'(bus.o_State), 1);
    bus.i_Push[0] = 1'b1;
    wait_tick("restart", 16, c);
    check("restart_lat", c, 8);
    check("restart_way", 32'(bus.o_Way), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
